measurement_sequencer: RTL and testbench

Top-level controller for one time-of-flight measurement cycle. It arms the four trigger counter channels on an emitter start pulse, and waits until every channel has captured or a timeout expires. It then requests one UART frame and clears the counters once the frame is sent. A holdoff period follows before the next start is accepted. Sits between the emitter start input, the four counter channels, the data combiner and the UART buffer.

---
 rtl/meas_seq_pkg.sv | 18 +
 rtl/measurement_sequencer.sv | 151 +++++++++++++++
 tb/tb_measurement_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_seq_pkg.sv
// Shared types and default sizing for the time-of-flight measurement sequencer.
package meas_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    REPORT,
    WAIT_TX,
    CLEAR,
    HOLDOFF
  } meas_state_e;

  localparam int unsigned N_CH_DEFAULT         = 4;
  localparam int unsigned TIMEOUT_CLKS_DEFAULT = 1000000;
  localparam int unsigned HOLDOFF_CLKS_DEFAULT = 100000;
  localparam int unsigned CNT_W_DEFAULT        = 24;

endpackage

// File: rtl/measurement_sequencer.sv
// Sequences one measurement: arm counters on a start edge, collect hits or time out,
// request a UART frame, clear the counters, then hold off before the next start.
module measurement_sequencer
  import meas_seq_pkg::*;
#(
  parameter int unsigned N_CH         = N_CH_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT,
  parameter int unsigned HOLDOFF_CLKS = HOLDOFF_CLKS_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_CH-1:0] ch_valid,
  input  logic            tx_done,
  output logic            arm,
  output logic            frame_req,
  output logic            clear,
  output logic [N_CH-1:0] hit_mask,
  output logic            timeout_flag,
  output logic            busy,
  output logic [7:0]      seq_num,
  output logic [7:0]      missed_starts
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CLKS - 1);
  localparam logic [CNT_W-1:0] TimerOne    = CNT_W'(1);

  meas_state_e     state_q, state_d;
  logic            start_q;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_CH-1:0] hit_mask_q, hit_mask_d;
  logic            timeout_flag_q, timeout_flag_d;
  logic [7:0]      seq_num_q, seq_num_d;
  logic [7:0]      missed_q, missed_d;
  logic            arm_q, arm_d;
  logic            frame_req_q, frame_req_d;
  logic            clear_q, clear_d;
  logic            busy_q, busy_d;

  logic start_edge;
  logic all_hit;

  assign start_edge = start & ~start_q;
  assign all_hit    = &(hit_mask_q | ch_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    hit_mask_d     = hit_mask_q;
    timeout_flag_d = timeout_flag_q;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d        = ARMED;
          timer_d        = '0;
          hit_mask_d     = '0;
          timeout_flag_d = 1'b0;
        end
      end
      ARMED: begin
        hit_mask_d = hit_mask_q | ch_valid;
        timer_d    = timer_q + TimerOne;
        // A full mask on the last timer cycle still counts as a clean capture.
        if (all_hit) begin
          state_d        = REPORT;
          timeout_flag_d = 1'b0;
        end else if (timer_q == TimeoutLast) begin
          state_d        = REPORT;
          timeout_flag_d = 1'b1;
        end
      end
      REPORT: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        timer_d = '0;
        state_d = (HOLDOFF_CLKS == 0) ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        if (timer_q == HoldoffLast) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse outputs are decoded from the current state and registered, adding one cycle.
  always_comb begin
    arm_d       = (state_q == ARMED);
    frame_req_d = (state_q == REPORT);
    clear_d     = (state_q == CLEAR);
    busy_d      = (state_d != IDLE);
    seq_num_d   = clear_d ? seq_num_q + 8'd1 : seq_num_q;
    missed_d    = missed_q;
    if (start_edge && (state_q != IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q        <= 1'b0;
      timer_q        <= '0;
      hit_mask_q     <= '0;
      timeout_flag_q <= 1'b0;
      seq_num_q      <= 8'd0;
      missed_q       <= 8'd0;
      arm_q          <= 1'b0;
      frame_req_q    <= 1'b0;
      clear_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      start_q        <= start;
      timer_q        <= timer_d;
      hit_mask_q     <= hit_mask_d;
      timeout_flag_q <= timeout_flag_d;
      seq_num_q      <= seq_num_d;
      missed_q       <= missed_d;
      arm_q          <= arm_d;
      frame_req_q    <= frame_req_d;
      clear_q        <= clear_d;
      busy_q         <= busy_d;
    end
  end

  assign arm           = arm_q;
  assign frame_req     = frame_req_q;
  assign clear         = clear_q;
  assign hit_mask      = hit_mask_q;
  assign timeout_flag  = timeout_flag_q;
  assign busy          = busy_q;
  assign seq_num       = seq_num_q;
  assign missed_starts = missed_q;

endmodule

// File: tb/tb_measurement_sequencer.sv
// Scoreboard bench for measurement_sequencer: expected frames and clears are queued by
// the stimulus and matched (content and cycle) by a negedge monitor.
module tb_measurement_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned TO  = 50;
  localparam int unsigned HO  = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [NCH-1:0] ch_valid = '0;
  logic           tx_done = 1'b0;
  logic           arm, frame_req, clear, timeout_flag, busy;
  logic [NCH-1:0] hit_mask;
  logic [7:0]     seq_num, missed_starts;

  measurement_sequencer #(
    .N_CH        (NCH),
    .TIMEOUT_CLKS(TO),
    .HOLDOFF_CLKS(HO),
    .CNT_W       (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ch_valid     (ch_valid),
    .tx_done      (tx_done),
    .arm          (arm),
    .frame_req    (frame_req),
    .clear        (clear),
    .hit_mask     (hit_mask),
    .timeout_flag (timeout_flag),
    .busy         (busy),
    .seq_num      (seq_num),
    .missed_starts(missed_starts)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int unsigned    at;
    logic [NCH-1:0] mask;
    logic           to;
  } frame_t;

  typedef struct {
    int unsigned at;
    logic [7:0]  seq;
  } clr_t;

  frame_t frame_q[$];
  clr_t   clr_q[$];

  // Monitor: every frame_req / clear pulse must match the head of its queue.
  always @(negedge clk) begin
    if (frame_req) begin
      if (frame_q.size() == 0) begin
        check("frame_unexpected", 32'd1, 32'd0);
      end else begin
        frame_t f;
        f = frame_q.pop_front();
        check("frame_cycle", cyc, f.at);
        check("frame_hit_mask", 32'(hit_mask), 32'(f.mask));
        check("frame_timeout_flag", 32'(timeout_flag), 32'(f.to));
      end
    end
    if (clear) begin
      if (clr_q.size() == 0) begin
        check("clear_unexpected", 32'd1, 32'd0);
      end else begin
        clr_t c;
        c = clr_q.pop_front();
        check("clear_cycle", cyc, c.at);
        check("clear_seq_num", 32'(seq_num), 32'(c.seq));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  // Start driven at cycle p is sampled at edge p+1; ARMED cycle j is cycle p+1+j.
  task automatic start_pulse(output int unsigned p);
    start = 1'b1;
    p = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_tx(output int unsigned t);
    tx_done = 1'b1;
    t = cyc;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arm"}, 32'(arm), 32'd0);
    check({tag, "_frame_req"}, 32'(frame_req), 32'd0);
    check({tag, "_clear"}, 32'(clear), 32'd0);
    check({tag, "_hit_mask"}, 32'(hit_mask), 32'd0);
    check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_seq_num"}, 32'(seq_num), 32'd0);
    check({tag, "_missed"}, 32'(missed_starts), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned p, t, d;

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // All-hit: bits at ARMED cycles 3, 7, 12, 20.
    start_pulse(p);
    frame_q.push_back('{at: p + 23, mask: 4'hF, to: 1'b0});
    check("allhit_arm_not_yet", 32'(arm), 32'd0);
    wait_until(p + 2);
    check("allhit_arm_rise", 32'(arm), 32'd1);
    check("allhit_busy", 32'(busy), 32'd1);
    wait_until(p + 4);  ch_valid[0] = 1'b1;
    wait_until(p + 8);  ch_valid[1] = 1'b1;
    wait_until(p + 13); ch_valid[2] = 1'b1;
    wait_until(p + 21); ch_valid[3] = 1'b1;
    wait_until(p + 24);
    check("allhit_arm_low", 32'(arm), 32'd0);
    ch_valid = '0;
    wait_until(p + 23 + 30);
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd1});
    wait_until(t + 11);
    check("holdoff_busy_high", 32'(busy), 32'd1);
    tick();
    check("holdoff_busy_low", 32'(busy), 32'd0);
    wait_until(t + 14);

    // Timeout: only channels 0 and 2.
    start_pulse(p);
    frame_q.push_back('{at: p + TO + 2, mask: 4'b0101, to: 1'b1});
    wait_until(p + 6);
    ch_valid = 4'b0101;
    wait_until(p + TO + 1);
    check("timeout_arm_last", 32'(arm), 32'd1);
    tick();
    check("timeout_arm_drop", 32'(arm), 32'd0);
    wait_until(p + TO + 3);
    ch_valid = '0;
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd2});
    wait_until(t + 14);

    // Final bit on timer == TO-1: all-hit wins.
    start_pulse(p);
    frame_q.push_back('{at: p + TO + 2, mask: 4'hF, to: 1'b0});
    wait_until(p + 3);
    ch_valid = 4'b0111;
    wait_until(p + TO);
    ch_valid = 4'hF;
    wait_until(p + TO + 3);
    ch_valid = '0;
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd3});
    wait_until(t + 14);

    // Missed starts: three in WAIT_TX, one in HOLDOFF.
    start_pulse(p);
    ch_valid = 4'hF;
    frame_q.push_back('{at: p + 3, mask: 4'hF, to: 1'b0});
    wait_until(p + 4);
    ch_valid = '0;
    repeat (3) begin
      start_pulse(d);
      tick();
    end
    check("missed_three", 32'(missed_starts), 32'd3);
    check("missed_busy", 32'(busy), 32'd1);
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd4});
    wait_until(t + 4);
    start_pulse(d);
    check("missed_holdoff", 32'(missed_starts), 32'd4);
    wait_until(t + 14);
    check("missed_idle_busy", 32'(busy), 32'd0);

    // Saturation: 300 more misses in WAIT_TX.
    start_pulse(p);
    ch_valid = 4'hF;
    frame_q.push_back('{at: p + 3, mask: 4'hF, to: 1'b0});
    wait_until(p + 4);
    ch_valid = '0;
    repeat (300) begin
      start_pulse(d);
      tick();
    end
    check("missed_saturate", 32'(missed_starts), 32'd255);
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd5});
    wait_until(t + 14);

    // Stale inputs: ch_valid held and tx_done pulsed in IDLE, tx_done in ARMED.
    ch_valid = 4'hF;
    repeat (3) tick();
    pulse_tx(d);
    repeat (4) tick();
    check("stale_idle_busy", 32'(busy), 32'd0);
    start_pulse(p);
    frame_q.push_back('{at: p + 3, mask: 4'hF, to: 1'b0});
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("stale_arm", 32'(arm), 32'd1);
    wait_until(p + 10);
    ch_valid = '0;
    check("stale_wait_busy", 32'(busy), 32'd1);
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd6});
    wait_until(t + 14);

    // Reset while waiting on the UART.
    start_pulse(p);
    ch_valid = 4'hF;
    frame_q.push_back('{at: p + 3, mask: 4'hF, to: 1'b0});
    wait_until(p + 6);
    ch_valid = '0;
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (5) tick();
    check("post_reset_busy", 32'(busy), 32'd0);
    start_pulse(p);
    ch_valid = 4'hF;
    frame_q.push_back('{at: p + 3, mask: 4'hF, to: 1'b0});
    wait_until(p + 6);
    ch_valid = '0;
    pulse_tx(t);
    clr_q.push_back('{at: t + 2, seq: 8'd1});
    wait_until(t + 14);

    check("frames_drained", 32'(frame_q.size()), 32'd0);
    check("clears_drained", 32'(clr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
